// File: rtl/emu_clk_pkg.sv
// Shared types for the emulator clock controller.
package emu_clk_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    STEP  = ST_STEP
  } emu_clk_state_t;

  function automatic emu_clk_state_t reset_state(input bit start_paused);
    return start_paused ? PAUSE : RUN;
  endfunction

endpackage

// File: rtl/emu_clk_buf.sv
// Clock buffer wrapper for emu_clk and each derived clock.
// Passthrough model; the implementation flow swaps in the global buffer primitive.
module emu_clk_buf (
  input  logic clk_src,
  output logic clk_buf
);

  assign clk_buf = clk_src;

endmodule

// File: rtl/gen_emu_clks_ctrl.sv
// Emulator clock generator: emu_clk = emu_clk_2x/2 with pause/single-step
// control and N gated derived clocks updated on each emu_clk rise.
// Optional emu_clk rise counter enabled by defining EMU_CYCLE_COUNTER_EN.
module gen_emu_clks_ctrl #(
  parameter int unsigned N            = 2,
  parameter int unsigned CNT_W        = 64,
  parameter bit          START_PAUSED = 1'b0
) (
  input  logic             emu_clk_2x,
  input  logic             emu_rst,
  output logic             emu_clk,
  input  logic [N-1:0]     clk_vals,
  input  logic [N-1:0]     clk_en,
  output logic [N-1:0]     clks,
  input  logic             emu_pause,
  input  logic             step_req,
  output logic             step_done,
  output logic             emu_running,
  output logic [CNT_W-1:0] emu_cycle
);

  import emu_clk_pkg::*;

  emu_clk_state_t state;
  emu_clk_state_t state_next;
  logic           ph;
  logic           ph_next;
  logic           rise;
  logic [N-1:0]   clks_q;

  // State register: FSM state and emu_clk phase.
  always_ff @(posedge emu_clk_2x) begin
    if (emu_rst) begin
      state <= reset_state(START_PAUSED);
      ph    <= 1'b0;
    end else begin
      state <= state_next;
      ph    <= ph_next;
    end
  end

  // Next state: decisions only in the rise slot (ph==0); a high phase always falls.
  always_comb begin
    state_next = state;
    ph_next    = 1'b0;
    if (!ph) begin
      case (state)
        RUN: begin
          if (emu_pause) state_next = PAUSE;
          else           ph_next    = 1'b1;
        end
        PAUSE: begin
          if (!emu_pause) begin
            state_next = RUN;
            ph_next    = 1'b1;
          end else if (step_req) begin
            state_next = STEP;
            ph_next    = 1'b1;
          end
        end
        default: state_next = PAUSE;
      endcase
    end else if (state == STEP) begin
      state_next = PAUSE;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    rise        = !ph && ph_next;
    emu_running = (state != PAUSE);
  end

  // Derived-clock channels and step completion pulse.
  always_ff @(posedge emu_clk_2x) begin
    if (emu_rst) begin
      clks_q    <= '0;
      step_done <= 1'b0;
    end else begin
      step_done <= ph && (state == STEP);
      if (rise) clks_q <= clk_vals & clk_en;
    end
  end

`ifdef EMU_CYCLE_COUNTER_EN
  logic [CNT_W-1:0] cycle_q;

  // Count emu_clk rises; wraps naturally at 2^CNT_W.
  always_ff @(posedge emu_clk_2x) begin
    if (emu_rst)   cycle_q <= '0;
    else if (rise) cycle_q <= cycle_q + CNT_W'(1);
  end

  assign emu_cycle = cycle_q;
`else
  assign emu_cycle = '0;
`endif

  emu_clk_buf u_emu_clk_buf (
    .clk_src (ph),
    .clk_buf (emu_clk)
  );

  for (genvar k = 0; k < N; k++) begin : g_chan
    emu_clk_buf u_clk_buf (
      .clk_src (clks_q[k]),
      .clk_buf (clks[k])
    );
  end

endmodule

// File: tb/tb_gen_emu_clks_ctrl.sv
// Self-checking bench for gen_emu_clks_ctrl (N=2, CNT_W=4) plus a START_PAUSED instance.
module tb_gen_emu_clks_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] clk_vals;
  logic [1:0] clk_en;
  logic       pause;
  logic       step;
  logic       emu_clk;
  logic [1:0] clks;
  logic       step_done;
  logic       emu_running;
  logic [3:0] emu_cycle;

  logic       sp_pause;
  logic       sp_step;
  logic       sp_emu_clk;
  logic [0:0] sp_clks;
  logic       sp_step_done;
  logic       sp_running;
  logic [7:0] sp_cycle;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic       m_clk;
  logic       m_paused;
  logic       m_stepping;
  logic       m_done;
  logic       m_rise;
  logic [1:0] m_clks;
  int         m_cnt;

  gen_emu_clks_ctrl #(.N(2), .CNT_W(4), .START_PAUSED(1'b0)) dut (
    .emu_clk_2x  (clk),
    .emu_rst     (rst),
    .emu_clk     (emu_clk),
    .clk_vals    (clk_vals),
    .clk_en      (clk_en),
    .clks        (clks),
    .emu_pause   (pause),
    .step_req    (step),
    .step_done   (step_done),
    .emu_running (emu_running),
    .emu_cycle   (emu_cycle)
  );

  gen_emu_clks_ctrl #(.N(1), .CNT_W(8), .START_PAUSED(1'b1)) dut_sp (
    .emu_clk_2x  (clk),
    .emu_rst     (rst),
    .emu_clk     (sp_emu_clk),
    .clk_vals    (clk_vals[0:0]),
    .clk_en      (clk_en[0:0]),
    .clks        (sp_clks),
    .emu_pause   (sp_pause),
    .step_req    (sp_step),
    .step_done   (sp_step_done),
    .emu_running (sp_running),
    .emu_cycle   (sp_cycle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] exp_cycle(input int rises);
`ifdef EMU_CYCLE_COUNTER_EN
    return 64'(rises % 16);
`else
    return 64'(rises - rises);
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: emu_clk is a level that rises only from low when allowed and always falls after one cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_clk      = 1'b0;
      m_paused   = 1'b0;
      m_stepping = 1'b0;
      m_done     = 1'b0;
      m_clks     = 2'b00;
      m_cnt      = 0;
    end else begin
      m_done = 1'b0;
      m_rise = 1'b0;
      if (m_clk) begin
        m_clk = 1'b0;
        if (m_stepping) begin
          m_stepping = 1'b0;
          m_paused   = 1'b1;
          m_done     = 1'b1;
        end
      end else if (!m_paused) begin
        if (pause) m_paused = 1'b1;
        else       m_rise   = 1'b1;
      end else if (!pause) begin
        m_paused = 1'b0;
        m_rise   = 1'b1;
      end else if (step) begin
        m_paused   = 1'b0;
        m_stepping = 1'b1;
        m_rise     = 1'b1;
      end
      if (m_rise) begin
        m_clk  = 1'b1;
        m_clks = clk_vals & clk_en;
        m_cnt  = m_cnt + 1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("emu_clk", 64'(emu_clk), 64'(m_clk));
      chk("clks", 64'(clks), 64'(m_clks));
      chk("step_done", 64'(step_done), 64'(m_done));
      chk("emu_running", 64'(emu_running), 64'(!m_paused));
      chk("emu_cycle", 64'(emu_cycle), exp_cycle(m_cnt));
      if (sp_pause) chk("sp_emu_clk_paused", 64'(sp_emu_clk), 64'd0);
    end
  end

  initial begin
    rst      = 1'b1;
    clk_vals = 2'b01;
    clk_en   = 2'b11;
    pause    = 1'b0;
    step     = 1'b0;
    sp_pause = 1'b1;
    sp_step  = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("rst_emu_clk", 64'(emu_clk), 64'd0);
    chk("rst_clks", 64'(clks), 64'd0);
    chk("rst_running", 64'(emu_running), 64'd1);
    chk("rst_step_done", 64'(step_done), 64'd0);
    chk("rst_cycle", 64'(emu_cycle), 64'd0);

    // Free run: first rise carries clk_vals; 10 rises in 20 edges; step_req ignored in RUN
    rst = 1'b0;
    cyc(1);
    chk("first_rise_emu_clk", 64'(emu_clk), 64'd1);
    chk("first_rise_clks", 64'(clks), 64'h1);
    cyc(9);
    step = 1'b1;
    cyc(2);
    step = 1'b0;
    cyc(8);
    chk("ten_rises_cycle", 64'(emu_cycle), exp_cycle(10));
    chk("ten_rises_emu_clk", 64'(emu_clk), 64'd0);

    // Toggle channel 0 each period, then disable it while high
    for (int i = 0; i < 4; i++) begin
      clk_vals[0] = ~clk_vals[0];
      cyc(2);
    end
    chk("chan0_high", 64'(clks), 64'h1);
    clk_en = 2'b10;
    cyc(1);
    chk("chan0_gated", 64'(clks), 64'h0);
    clk_en = 2'b11;

    // Pause requested during high phase: completes high, then holds low
    pause = 1'b1;
    cyc(1);
    chk("pause_fall", 64'(emu_clk), 64'd0);
    cyc(1);
    chk("paused_running", 64'(emu_running), 64'd0);
    chk("paused_cycle", 64'(emu_cycle), exp_cycle(15));
    cyc(4);
    chk("paused_hold_clk", 64'(emu_clk), 64'd0);
    chk("paused_hold_cycle", 64'(emu_cycle), exp_cycle(15));

    // Single step, with a redundant request during STEP; counter wraps 15 -> 0
    step = 1'b1;
    cyc(1);
    chk("step_high", 64'(emu_clk), 64'd1);
    chk("step_running", 64'(emu_running), 64'd1);
    chk("step_wrap", 64'(emu_cycle), 64'd0);
    cyc(1);
    chk("step_done_pulse", 64'(step_done), 64'd1);
    chk("step_fall", 64'(emu_clk), 64'd0);
    chk("step_back_paused", 64'(emu_running), 64'd0);
    step = 1'b0;
    cyc(1);
    chk("step_done_clear", 64'(step_done), 64'd0);
    chk("no_extra_pulse", 64'(emu_clk), 64'd0);
    cyc(3);

    // Release pause with simultaneous step_req: RUN wins
    pause = 1'b0;
    step  = 1'b1;
    cyc(1);
    chk("release_rise", 64'(emu_clk), 64'd1);
    chk("release_running", 64'(emu_running), 64'd1);
    step = 1'b0;
    cyc(1);
    chk("release_no_step_done", 64'(step_done), 64'd0);
    cyc(5);
    chk("pre_rst_high", 64'(emu_clk), 64'd1);

    // Reset mid-high
    rst = 1'b1;
    cyc(1);
    chk("midrst_emu_clk", 64'(emu_clk), 64'd0);
    chk("midrst_clks", 64'(clks), 64'd0);
    chk("midrst_cycle", 64'(emu_cycle), 64'd0);
    chk("midrst_running", 64'(emu_running), 64'd1);
    rst = 1'b0;
    cyc(4);

    // START_PAUSED instance stays low until released
    chk("sp_clk", 64'(sp_emu_clk), 64'd0);
    chk("sp_running", 64'(sp_running), 64'd0);
    chk("sp_cycle", 64'(sp_cycle), 64'd0);
    chk("sp_step_done", 64'(sp_step_done), 64'd0);
    sp_pause = 1'b0;
    cyc(1);
    chk("sp_release_clk", 64'(sp_emu_clk), 64'd1);
    chk("sp_release_running", 64'(sp_running), 64'd1);
    chk("sp_release_clks", 64'(sp_clks), 64'h1);
    cyc(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
